// File: rtl/ccff_pkg.sv
// Shared sizing helpers for the shadowed configuration chain.
// Beat count, counter width and parameter sanity check.
package ccff_pkg;

   // Number of beats needed to fill a chain of depth bits.
   function automatic int ccff_beats(input int depth, input int width);
      return (width < 1) ? 0 : depth / width;
   endfunction

   // Counter width able to hold 0..beats inclusive.
   function automatic int ccff_cnt_w(input int beats);
      return (beats < 1) ? 1 : $clog2(beats + 1);
   endfunction

   // Depth must be a whole number of beats of at least one lane.
   function automatic bit ccff_cfg_ok(input int depth, input int width);
      return (width >= 1) && (depth >= width) && ((depth % width) == 0);
   endfunction

endpackage

// File: rtl/ccff_beat_counter.sv
// Saturating beat counter with clear.
// loaded is high once the chain holds a full set of beats.
module ccff_beat_counter
   import ccff_pkg::*;
#(
   parameter int BEATS = 17,
   parameter int CW    = ccff_cnt_w(BEATS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          loaded
);

   localparam logic [CW-1:0] FULL = CW'(BEATS);

   // Count shifted beats; saturate at full, clear on accepted commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != FULL)) begin
         count <= count + CW'(1);
      end
   end

   assign loaded = (count == FULL);

endmodule

// File: rtl/ccff_shadow_mem.sv
// Configuration chain with a shift stage and a committed shadow register.
// The fabric only ever sees fully loaded, atomically committed settings.
module ccff_shadow_mem
   import ccff_pkg::*;
#(
   parameter int   DEPTH     = 17,
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic             prog_clk,
   input  logic             prog_reset,
   input  logic [WIDTH-1:0] ccff_head,
   input  logic             ccff_shift_en,
   output logic [WIDTH-1:0] ccff_tail,
   input  logic             commit,
   output logic [DEPTH-1:0] mem_out,
   output logic [DEPTH-1:0] mem_outb,
   output logic             loaded,
   output logic             commit_err
);

   localparam int BEATS = ccff_beats(DEPTH, WIDTH);
   localparam int CW    = ccff_cnt_w(BEATS);

   if (!ccff_cfg_ok(DEPTH, WIDTH)) begin : g_bad_cfg
      $error("ccff_shadow_mem: DEPTH must be a multiple of WIDTH >= 1");
   end

   logic [DEPTH-1:0] sh;
   logic [DEPTH-1:0] act;
   logic [CW-1:0]    count;
   logic             commit_ok;

   // A commit lands only on a full chain that is not moving this cycle.
   assign commit_ok = commit & loaded & ~ccff_shift_en;

   // Shift stage: new beat enters the low lanes, older beats move up.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         sh <= '0;
      end else if (ccff_shift_en) begin
         sh <= (sh << WIDTH) | DEPTH'(ccff_head);
      end
   end

   // Active register: changes only on reset or an accepted commit.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         act <= {DEPTH{RESET_VAL}};
      end else if (commit_ok) begin
         act <= sh;
      end
   end

   // Flag a rejected commit for exactly one cycle.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         commit_err <= 1'b0;
      end else begin
         commit_err <= commit & ~commit_ok;
      end
   end

   ccff_beat_counter #(
      .BEATS (BEATS),
      .CW    (CW)
   ) u_cnt (
      .clk    (prog_clk),
      .rst    (prog_reset),
      .inc    (ccff_shift_en),
      .clr    (commit_ok),
      .count  (count),
      .loaded (loaded)
   );

   assign ccff_tail = sh[DEPTH-1 -: WIDTH];
   assign mem_out   = act;
   assign mem_outb  = ~act;

endmodule

// File: tb/tb_ccff_shadow_mem.sv
// Bench for ccff_shadow_mem: three configurations against a beat-history model.
// Expected state is rebuilt from the list of beats shifted in.
module tb_ccff_shadow_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        r0 = 0, s0 = 0, c0 = 0, h0 = 0;
   logic        t0, ld0, e0;
   logic [16:0] m0, mb0;
   logic        r1 = 0, s1 = 0, c1 = 0;
   logic [3:0]  h1 = 0, t1;
   logic        ld1, e1;
   logic [15:0] m1, mb1;
   logic        r2 = 0, s2 = 0, c2 = 0, h2 = 0;
   logic        t2, ld2, e2;
   logic [16:0] m2, mb2;

   ccff_shadow_mem #(.DEPTH(17), .WIDTH(1), .RESET_VAL(1'b0)) u0 (
      .prog_clk(clk), .prog_reset(r0), .ccff_head(h0), .ccff_shift_en(s0),
      .ccff_tail(t0), .commit(c0), .mem_out(m0), .mem_outb(mb0),
      .loaded(ld0), .commit_err(e0));

   ccff_shadow_mem #(.DEPTH(16), .WIDTH(4), .RESET_VAL(1'b0)) u1 (
      .prog_clk(clk), .prog_reset(r1), .ccff_head(h1), .ccff_shift_en(s1),
      .ccff_tail(t1), .commit(c1), .mem_out(m1), .mem_outb(mb1),
      .loaded(ld1), .commit_err(e1));

   ccff_shadow_mem #(.DEPTH(17), .WIDTH(1), .RESET_VAL(1'b1)) u2 (
      .prog_clk(clk), .prog_reset(r2), .ccff_head(h2), .ccff_shift_en(s2),
      .ccff_tail(t2), .commit(c2), .mem_out(m2), .mem_outb(mb2),
      .loaded(ld2), .commit_err(e2));

   int dep [3] = '{17, 16, 17};
   int wid [3] = '{1, 4, 1};
   int rv  [3] = '{0, 0, 1};

   int          hist [3][$];
   int          cnt_m [3];
   logic [31:0] mem_m [3];
   logic        err_m [3];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [31:0] msk(input int d);
      return (32'h1 << dep[d]) - 32'h1;
   endfunction

   // Chain image: newest beat in the low lanes, each older beat one beat higher.
   function automatic logic [31:0] stage(input int d);
      logic [31:0] s;
      int n, b;
      s = '0;
      n = hist[d].size();
      b = dep[d] / wid[d];
      for (int a = 0; a < b && a < n; a++)
         s |= 32'(hist[d][n-1-a]) << (a * wid[d]);
      return s & msk(d);
   endfunction

   function automatic logic [31:0] tail_m(input int d);
      return (stage(d) >> (dep[d] - wid[d])) & ((32'h1 << wid[d]) - 32'h1);
   endfunction

   function automatic logic ld_m(input int d);
      return cnt_m[d] == dep[d] / wid[d];
   endfunction

   task automatic do_cycle(input int d, input bit rst, input bit sh,
                           input logic [3:0] h, input bit cm);
      int  beats;
      bit  acc;
      case (d)
         0: begin r0 = rst; s0 = sh; h0 = h[0]; c0 = cm; end
         1: begin r1 = rst; s1 = sh; h1 = h;    c1 = cm; end
         default: begin r2 = rst; s2 = sh; h2 = h[0]; c2 = cm; end
      endcase
      @(posedge clk);
      #1;
      {r0, s0, c0, r1, s1, c1, r2, s2, c2} = '0;
      beats = dep[d] / wid[d];
      if (rst) begin
         hist[d].delete();
         cnt_m[d] = 0;
         mem_m[d] = rv[d] != 0 ? msk(d) : 32'h0;
         err_m[d] = 1'b0;
      end else begin
         acc = cm && !sh && cnt_m[d] == beats;
         err_m[d] = cm && !acc;
         if (acc) begin
            mem_m[d] = stage(d);
            cnt_m[d] = 0;
         end
         if (sh) begin
            hist[d].push_back(int'(h) & ((1 << wid[d]) - 1));
            if (cnt_m[d] < beats) cnt_m[d]++;
            if (hist[d].size() > beats) void'(hist[d].pop_front());
         end
      end
      @(negedge clk);
   endtask

   task automatic obs(input int d, output logic [31:0] mo, output logic [31:0] mb,
                      output logic [31:0] tl, output logic ld, output logic er);
      case (d)
         0: begin mo = 32'(m0); mb = 32'(mb0); tl = 32'(t0); ld = ld0; er = e0; end
         1: begin mo = 32'(m1); mb = 32'(mb1); tl = 32'(t1); ld = ld1; er = e1; end
         default: begin mo = 32'(m2); mb = 32'(mb2); tl = 32'(t2); ld = ld2; er = e2; end
      endcase
   endtask

   task automatic test_reset;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      for (int d = 0; d < 3; d++) begin
         do_cycle(d, 1, 1, 4'hf, 1);
         obs(d, mo, mb, tl, ld, er);
         n_chk++;
         if (mo !== (rv[d] != 0 ? msk(d) : 32'h0)) begin
            n_fail++; $display("FAIL reset_mem dut%0d got %h want %h", d, mo, mem_m[d]);
         end
         n_chk++;
         if (mb !== (~mem_m[d] & msk(d))) begin
            n_fail++; $display("FAIL reset_memb dut%0d got %h want %h", d, mb, ~mem_m[d] & msk(d));
         end
         n_chk++;
         if (ld !== 1'b0 || er !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags dut%0d got ld=%b err=%b want 0 0", d, ld, er);
         end
         n_chk++;
         if (tl !== 32'h0) begin
            n_fail++; $display("FAIL reset_tail dut%0d got %h want 0", d, tl);
         end
      end
   endtask

   task automatic test_pattern;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      do_cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 17; i++) do_cycle(0, 0, 1, (i % 2 == 0) ? 4'h1 : 4'h0, 0);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (ld !== 1'b1 || mo !== 32'h0) begin
         n_fail++; $display("FAIL pattern_preload got ld=%b mem=%h want 1 0", ld, mo);
      end
      do_cycle(0, 0, 0, 0, 1);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (mo !== 32'h15555) begin
         n_fail++; $display("FAIL pattern_mem got %h want 15555", mo);
      end
      n_chk++;
      if (mb !== 32'h0aaaa) begin
         n_fail++; $display("FAIL pattern_memb got %h want 0aaaa", mb);
      end
      n_chk++;
      if (ld !== 1'b0 || er !== 1'b0) begin
         n_fail++; $display("FAIL pattern_flags got ld=%b err=%b want 0 0", ld, er);
      end
   endtask

   task automatic test_partial;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      do_cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) do_cycle(0, 0, 1, 4'($urandom), 0);
      do_cycle(0, 0, 0, 0, 1);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (er !== 1'b1 || ld !== 1'b0 || mo !== 32'h0) begin
         n_fail++; $display("FAIL partial_commit got err=%b ld=%b mem=%h want 1 0 0", er, ld, mo);
      end
      do_cycle(0, 0, 0, 0, 0);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (er !== 1'b0) begin
         n_fail++; $display("FAIL partial_err_pulse got %b want 0", er);
      end
      do_cycle(0, 0, 1, 4'($urandom), 0);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (ld !== 1'b1 || ld !== ld_m(0)) begin
         n_fail++; $display("FAIL partial_last_beat got ld=%b want 1", ld);
      end
   endtask

   task automatic test_wide;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      do_cycle(1, 1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) do_cycle(1, 0, 1, 4'(i), 0);
      obs(1, mo, mb, tl, ld, er);
      n_chk++;
      if (tl !== 32'h1 || ld !== 1'b1) begin
         n_fail++; $display("FAIL wide_tail got tail=%h ld=%b want 1 1", tl, ld);
      end
      do_cycle(1, 0, 0, 0, 1);
      obs(1, mo, mb, tl, ld, er);
      n_chk++;
      if (mo !== 32'h1234 || mb !== 32'hedcb) begin
         n_fail++; $display("FAIL wide_mem got %h/%h want 1234/edcb", mo, mb);
      end
   endtask

   task automatic test_commit_shift;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      do_cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 17; i++) do_cycle(0, 0, 1, 4'($urandom), 0);
      do_cycle(0, 0, 1, 4'($urandom), 1);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (er !== 1'b1 || mo !== 32'h0) begin
         n_fail++; $display("FAIL cs_reject got err=%b mem=%h want 1 0", er, mo);
      end
      n_chk++;
      if (tl !== tail_m(0) || ld !== 1'b1) begin
         n_fail++; $display("FAIL cs_shift got tail=%h ld=%b want %h 1", tl, ld, tail_m(0));
      end
      do_cycle(0, 0, 0, 0, 1);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (er !== 1'b0 || mo !== mem_m[0] || mo !== stage(0)) begin
         n_fail++; $display("FAIL cs_retry got err=%b mem=%h want 0 %h", er, mo, mem_m[0]);
      end
      do_cycle(0, 0, 0, 0, 1);
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (er !== 1'b1 || mo !== mem_m[0]) begin
         n_fail++; $display("FAIL back_to_back got err=%b mem=%h want 1 %h", er, mo, mem_m[0]);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      do_cycle(2, 1, 0, 0, 0);
      for (int i = 0; i < 17; i++) do_cycle(2, 0, 1, 4'($urandom), 0);
      do_cycle(2, 0, 0, 0, 1);
      obs(2, mo, mb, tl, ld, er);
      n_chk++;
      if (mo !== mem_m[2]) begin
         n_fail++; $display("FAIL rmid_commit got %h want %h", mo, mem_m[2]);
      end
      for (int i = 0; i < 5; i++) do_cycle(2, 0, 1, 4'h1, 0);
      do_cycle(2, 1, 1, 4'h1, 0);
      obs(2, mo, mb, tl, ld, er);
      n_chk++;
      if (mo !== 32'h1ffff || mb !== 32'h0) begin
         n_fail++; $display("FAIL rmid_mem got %h/%h want 1ffff/0", mo, mb);
      end
      n_chk++;
      if (ld !== 1'b0 || tl !== 32'h0) begin
         n_fail++; $display("FAIL rmid_state got ld=%b tail=%h want 0 0", ld, tl);
      end
   endtask

   task automatic test_overshift;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      logic [19:0] bits;
      logic [31:0] want;
      bits = 20'($urandom);
      do_cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) do_cycle(0, 0, 1, {3'b0, bits[i]}, 0);
      do_cycle(0, 0, 0, 0, 1);
      want = '0;
      for (int k = 0; k < 17; k++) want[k] = bits[19-k];
      obs(0, mo, mb, tl, ld, er);
      n_chk++;
      if (er !== 1'b0 || mo !== want) begin
         n_fail++; $display("FAIL overshift got err=%b mem=%h want 0 %h", er, mo, want);
      end
   endtask

   task automatic test_random;
      logic [31:0] mo, mb, tl;
      logic ld, er;
      int d;
      for (int i = 0; i < 400; i++) begin
         d = $urandom_range(0, 2);
         do_cycle(d, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  4'($urandom), $urandom_range(0, 5) == 0);
         obs(d, mo, mb, tl, ld, er);
         n_chk++;
         if (mo !== mem_m[d] || mb !== (~mem_m[d] & msk(d))) begin
            n_fail++; $display("FAIL rand_mem dut%0d cyc%0d got %h/%h want %h", d, i, mo, mb, mem_m[d]);
         end
         n_chk++;
         if (ld !== ld_m(d) || er !== err_m[d]) begin
            n_fail++; $display("FAIL rand_flags dut%0d cyc%0d got ld=%b err=%b want %b %b",
                               d, i, ld, er, ld_m(d), err_m[d]);
         end
         n_chk++;
         if (tl !== tail_m(d)) begin
            n_fail++; $display("FAIL rand_tail dut%0d cyc%0d got %h want %h", d, i, tl, tail_m(d));
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_pattern;
      test_partial;
      test_wide;
      test_commit_shift;
      test_reset_mid;
      test_overshift;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
